// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Start/operand/result bundle between the multiplier controller and its user.
interface booth_mult_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_mult_ctrl_booth_step.sv
// One radix-2 Booth iteration: optional add/subtract of M through the shared
// carry-lookahead adder, then a 65-bit arithmetic right shift.
module cla_adder
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  localparam int unsigned GROUPS = WIDTH / 4;

  logic [GROUPS-2:0] gp;
  logic [GROUPS-2:0] gg;
  logic [GROUPS-1:0] gc;
  logic [WIDTH-1:0]  c;

  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int unsigned k = 0; k < GROUPS - 1; k++) begin
      gp[k] = &p_in[4*k +: 4];
      gg[k] = g_in[4*k+3]
            | (p_in[4*k+3] & g_in[4*k+2])
            | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
            | (&p_in[4*k+1 +: 3] & g_in[4*k]);
    end
    gc[0] = cin;
    for (int unsigned k = 1; k < GROUPS; k++) begin
      gc[k] = gg[k-1] | (gp[k-1] & gc[k-1]);
    end
    c[0] = gc[0];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      if (i % 4 == 0) c[i] = gc[i/4];
      else            c[i] = g_in[i-1] | (p_in[i-1] & c[i-1]);
    end
    sum = (p_in & ~g_in) ^ c;
  end
endmodule

module booth_step
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [2*WIDTH:0] p_next
);
  booth_op_t        op;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_new;
  logic             sign;

  assign op     = booth_decode(q[0], q_m1);
  assign addend = (op == SUB) ? ~m : m;
  assign p_in   = acc | addend;
  assign g_in   = acc & addend;
  assign cin    = (op == SUB);

  cla_adder u_cla (
    .p_in (p_in),
    .g_in (g_in),
    .cin  (cin),
    .sum  (sum)
  );

  // Shifted-in sign is the 33rd sum bit rebuilt from operand signs, so a
  // -2^31 multiplicand cannot wrap the accumulator sign.
  always_comb begin
    acc_new = acc;
    sign    = acc[WIDTH-1];
    if (op != NOP) begin
      acc_new = sum;
      sign    = (acc[WIDTH-1] == addend[WIDTH-1]) ? acc[WIDTH-1] : sum[WIDTH-1];
    end
    p_next = {sign, acc_new, q};
  end
endmodule

// File: rtl/booth_mult_ctrl.sv
// Multi-cycle signed 32x32 Booth multiplier controller: FSM, counter,
// operand/product registers and latched result/overflow outputs.
module booth_mult_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  booth_mult_ctrl_if.slave  bus
);
  import mult_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH:0]   p;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   p_next;

  booth_step u_step (
    .acc    (p[2*WIDTH:WIDTH+1]),
    .q      (p[WIDTH:1]),
    .q_m1   (p[0]),
    .m      (m),
    .p_next (p_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      m                  <= '0;
      p                  <= '0;
      cnt                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (bus.ctrl_MULT) begin
        // A start in any state restarts; an aborted run never raises ready.
        m        <= bus.data_operandA;
        p        <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
        cnt      <= '0;
        state    <= RUN;
        bus.busy <= 1'b1;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN: begin
            p   <= p_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state              <= DONE;
              bus.busy           <= 1'b0;
              bus.data_resultRDY <= 1'b1;
              bus.data_result    <= p_next[WIDTH:1];
              bus.data_exception <= (p_next[2*WIDTH:WIDTH+1] != {WIDTH{p_next[WIDTH]}});
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed table, random operands
// against a 64-bit arithmetic model, and abort/reset/held-start sequences.
module tb_booth_mult_ctrl;
  logic clock;
  logic reset;

  booth_mult_ctrl_if #(.WIDTH(32)) bus ();

  booth_mult_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_res;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pr;
    pr = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {(pr[63:32] != {32{pr[31]}}), pr[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner[5];
    corner = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom();
  endfunction

  // Pulses start for one edge; cycle 1 is the cycle right after the start edge.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input string name);
    int          pulses;
    int          first;
    logic [31:0] got_res;
    logic        got_exc;
    pulses  = 0;
    first   = 0;
    got_res = '0;
    got_exc = 1'b0;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    check({name, "_busy"}, 64'(bus.busy), 64'(1));
    check({name, "_prev_held"}, 64'(bus.data_result), 64'(last_res));
    for (int c = 2; c <= 40; c++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY) begin
        pulses++;
        if (first == 0) begin
          first   = c;
          got_res = bus.data_result;
          got_exc = bus.data_exception;
          check({name, "_busy_done"}, 64'(bus.busy), 64'(0));
        end
      end
    end
    check({name, "_latency"}, 64'(first), 64'(33));
    check({name, "_pulses"}, 64'(pulses), 64'(1));
    check({name, "_result"}, 64'(got_res), 64'(exp_res));
    check({name, "_exception"}, 64'(got_exc), 64'(exp_exc));
    check({name, "_hold"}, 64'(bus.data_result), 64'(exp_res));
    last_res = exp_res;
  endtask

  initial begin
    int          pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] r;

    n_checks = 0;
    n_fail   = 0;
    last_res = '0;
    tbl[0] = '{32'd3,         32'd5,         32'h0000_000F, 1'b0, "3x5"};
    tbl[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0, "m7x6"};
    tbl[2] = '{32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, "maxx2"};
    tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxm1"};
    tbl[4] = '{32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "minx1"};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "minxmin"};

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #12;
    check("rst_result", 64'(bus.data_result), 64'(0));
    check("rst_exception", 64'(bus.data_exception), 64'(0));
    check("rst_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      do_mult(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc, tbl[i].name);
    end

    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      r = model(a, b);
      do_mult(a, b, r[31:0], r[32], "rand");
    end

    // Abort: 4x4 started, restarted with 2x3 on the tenth edge.
    pulses = 0;
    bus.data_operandA = 32'd4;
    bus.data_operandB = 32'd4;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("abort_no_rdy", 64'(pulses), 64'(0));
    do_mult(32'd2, 32'd3, 32'd6, 1'b0, "abort_restart");

    // Held start: three consecutive high edges, the last with 7x8.
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd9;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    do_mult(32'd7, 32'd8, 32'd56, 1'b0, "held_start");

    // Reset on the twentieth cycle of a multiply.
    pulses = 0;
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd7;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY) pulses++;
    end
    reset = 1'b1;
    #2;
    check("midrst_result", 64'(bus.data_result), 64'(0));
    check("midrst_exception", 64'(bus.data_exception), 64'(0));
    check("midrst_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("midrst_no_rdy", 64'(pulses), 64'(0));
    check("midrst_idle_busy", 64'(bus.busy), 64'(0));
    last_res = '0;

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
